// File: rtl/inc_reg_ctrl_if.sv
// Client request/ack bus plus the command/readback lines of the shared
// clear/load/increment register, bundled for the sequencer.
interface inc_reg_ctrl_if #(
  parameter int WIDTH = 4
);
  // client side
  logic [1:0]       req;
  logic [1:0]       op0;
  logic [WIDTH-1:0] arg0;
  logic [1:0]       op1;
  logic [WIDTH-1:0] arg1;
  logic [1:0]       ack;
  logic [WIDTH-1:0] rdata;
  logic             wrap;
  logic             busy;
  logic             gnt_id;
  // register side
  logic             reg_clear;
  logic             reg_load;
  logic             reg_inr;
  logic [WIDTH-1:0] reg_data;
  logic [WIDTH-1:0] reg_q;

  // Environment: the two clients and the register instance.
  modport master (
    output req, op0, arg0, op1, arg1, reg_q,
    input  ack, rdata, wrap, busy, gnt_id,
           reg_clear, reg_load, reg_inr, reg_data
  );

  // The sequencer/arbiter itself.
  modport slave (
    input  req, op0, arg0, op1, arg1, reg_q,
    output ack, rdata, wrap, busy, gnt_id,
           reg_clear, reg_load, reg_inr, reg_data
  );
endinterface

// File: rtl/inc_reg_ctrl.sv
// Two-client round-robin sequencer for a shared 4-bit clear/load/increment
// register: runs READ/CLEAR/LOAD/INC-N and returns q plus a wrap flag.
module inc_reg_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic         clk,
  input  logic         clear_n,
  inc_reg_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    SETTLE = 2'd2,
    ACK    = 2'd3
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_INC   = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             win;

  // Registered register-command lines
  logic             clr_q, clr_d;
  logic             ld_q, ld_d;
  logic             inr_q, inr_d;
  logic [WIDTH-1:0] data_q, data_d;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      arg_q   <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      clr_q   <= 1'b0;
      ld_q    <= 1'b0;
      inr_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      clr_q   <= clr_d;
      ld_q    <= ld_d;
      inr_q   <= inr_d;
      data_q  <= data_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    arg_d   = arg_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    win     = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          // The pointer only moves on contention; a lone requester
          // leaves the round-robin order untouched.
          if (bus.req == 2'b11) begin
            win    = ~last_q;
            last_d = win;
          end else begin
            win = bus.req[1];
          end
          gnt_d = win;
          op_d  = win ? bus.op1  : bus.op0;
          arg_d = win ? bus.arg1 : bus.arg0;
          cnt_d = CNT_W'(arg_d);
          acc_d = 1'b0;
          if ((op_d == OP_INC) && (arg_d == '0)) begin
            state_d = SETTLE;
          end else begin
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        if (op_q == OP_INC) begin
          // reg_q still shows the pre-increment value in this cycle
          acc_d = acc_q | (bus.reg_q == '1);
          if (cnt_q > CNT_W'(1)) begin
            cnt_d   = cnt_q - CNT_W'(1);
            state_d = EXEC;
          end else begin
            state_d = SETTLE;
          end
        end else begin
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        state_d = ACK;
      end

      ACK: begin
        acc_d   = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------
  // Commands are decoded from the next state so that their registered
  // copies line up exactly with the EXEC cycles.
  always_comb begin
    clr_d  = (state_d == EXEC) && (op_d == OP_CLEAR);
    ld_d   = (state_d == EXEC) && (op_d == OP_LOAD);
    inr_d  = (state_d == EXEC) && (op_d == OP_INC);
    data_d = ld_d ? arg_d : '0;

    bus.reg_clear = clr_q;
    bus.reg_load  = ld_q;
    bus.reg_inr   = inr_q;
    bus.reg_data  = data_q;

    bus.busy   = (state_q != IDLE);
    bus.gnt_id = gnt_q;
    bus.ack    = '0;
    bus.rdata  = '0;
    bus.wrap   = 1'b0;
    if (state_q == ACK) begin
      bus.ack   = {gnt_q, ~gnt_q};
      bus.rdata = bus.reg_q;
      bus.wrap  = acc_q;
    end
  end

endmodule

// File: doc/inc_reg_ctrl.md
Name: inc_reg_ctrl

Overview:
- Sequencer and two-client round-robin arbiter for the 4-bit clear/load/increment register (bit4inc4Reg_t4).
- Accepts operation requests from two clients, drives the register's clear/load/inr/data inputs, and reads back q.
- Returns completion, result and wrap status to the client that was granted.
- Sits between the clients and a single shared register instance.

Parameters:
- WIDTH, 4, width of data, arguments and readback; must match the register.
- CNT_W, 4, width of the increment repeat count.

Ports:
- clk  input  1  system clock, rising edge
- clear_n  input  1  asynchronous, active-low reset
- req  input  2  request per client; held high until that client's ack
- op0  input  2  client 0 opcode: 00 READ, 01 CLEAR, 10 LOAD, 11 INC
- arg0  input  WIDTH  client 0 argument: LOAD value, or INC repeat count
- op1  input  2  client 1 opcode
- arg1  input  WIDTH  client 1 argument
- ack  output  2  one-cycle completion pulse per client
- rdata  output  WIDTH  register q at completion; valid only while ack is high
- wrap  output  1  increment wrap status; valid only while ack is high
- busy  output  1  high in every state except IDLE
- gnt_id  output  1  index of the client being served; valid while busy
- reg_clear  output  1  drives the register clear input
- reg_load  output  1  drives the register load input
- reg_inr  output  1  drives the register inr input
- reg_data  output  WIDTH  drives the register data input
- reg_q  input  WIDTH  register q output

Behaviour:
- Register model: synchronous; priority clear > load > inr; q updates at the clock edge after a command.
- Reset (clear_n low, asynchronous):
  - state = IDLE.
  - All outputs = 0: ack, rdata, wrap, busy, gnt_id, reg_clear, reg_load, reg_inr, reg_data.
  - Round-robin pointer last = 1, so client 0 wins first.
  - Internal count and wrap accumulator = 0.
  - Reset mid-operation aborts the operation with no ack. The register may be left partially incremented.
- States: IDLE, EXEC, SETTLE, ACK. Command outputs are registered; each command is asserted exactly during EXEC cycles.
- IDLE:
  - If any req bit is high, grant and latch op, arg and gnt_id.
  - One requester: grant it. Both requesters: grant the client != last, then update last.
  - Next state is EXEC. Exception: INC with arg = 0 goes straight to SETTLE with no commands issued.
- EXEC:
  - READ: no command asserted; one cycle.
  - CLEAR: reg_clear = 1 for one cycle.
  - LOAD: reg_load = 1 and reg_data = arg for one cycle.
  - INC: reg_inr = 1 for exactly arg consecutive cycles. The down-counter is loaded with arg, and the block stays in EXEC while count > 1.
  - INC wrap detect: wrap accumulator |= (reg_q == all-ones) in each EXEC cycle. reg_q is the pre-increment value in that cycle.
  - reg_data = 0 except during LOAD.
- SETTLE: one cycle, no command asserted; q reflects the last command.
- ACK:
  - ack[gnt_id] = 1, rdata = reg_q, wrap = accumulator (0 for non-INC ops).
  - Next state is IDLE; the accumulator clears.
- The client must drop req on the edge where it sees ack. A req still high in IDLE is treated as a new request.
- op and arg changes while granted are ignored; they were latched at grant.
- Latency in cycles, from grant edge to the ack cycle:
  - READ, CLEAR, LOAD: ack in cycle 3.
  - INC N ≥ 1: ack in cycle N+2.
  - INC 0: ack in cycle 2.
- The arbiter never grants while busy. A request arriving during busy waits and is never dropped.
- Arithmetic: increment wraps modulo 2^WIDTH inside the register. wrap reports whether at least one wrap occurred; the number of wraps is not reported.

Test Plan:
- Reset, then client 0 LOAD 5 -> reg_load = 1 and reg_data = 5 for 1 cycle; ack[0] 3 cycles after grant; rdata = 5; wrap = 0.
- After LOAD 5, client 1 INC 3 -> reg_inr high for exactly 3 cycles; ack[1] at cycle 5; rdata = 8; wrap = 0.
- LOAD 14, then INC 4 -> rdata = 2, wrap = 1. Follow with INC 0 -> no reg_inr pulse; ack at cycle 2; rdata = 2; wrap = 0.
- Both req raised in the same cycle after reset -> client 0 served first, then client 1. Repeat with both held -> order alternates 1, 0.
- Client 0 CLEAR after LOAD 9 -> reg_clear pulses once; rdata = 0. READ -> no command pulses; rdata = current q.
- clear_n pulled low during INC 10 at its 4th EXEC cycle -> outputs 0 immediately; no ack. A new request after release is served normally, client 0 first.
